ext_stream_ctrl: RTL and testbench
==================================

Name: ext_stream_ctrl

Overview:
- Streaming sequencer for the INT8 extension datapath.
- Accepts one packed vector per handshake: LENGTH lanes of INT bits each, plus a per-vector mode (zero or sign).
- Drives the existing signExt/zeroExt pair and serialises the 2x-wide widened result back onto an input-width bus, in two beats with valid/ready.
- Sits between the operand buffer and the INT16 accumulate stage, so downstream never sees a 2x-wide bus.

Parameters:
- INT, `INT8 (8): lane width in bits; the only supported value.
- LENGTH, 16: lanes per vector; must be even.
- CNT_W, 16: width of the processed-vector counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  vector offered.
- in_ready  output  1  controller can take a vector this cycle.
- in_data  input  INT*LENGTH  packed lanes; lane j is in_data[j*INT +: INT].
- in_mode  input  1  0 = zero-extend, 1 = sign-extend; sampled with in_data.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  INT*LENGTH  LENGTH/2 widened lanes, each 2*INT bits.
- out_last  output  1  high on the second (upper-half) beat.
- busy  output  1  state != IDLE.
- vec_cnt  output  CNT_W  vectors fully delivered, i.e. second beat handshaken.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, out_last=0, out_data=0, vec_cnt=0; internal result register=0.
- FSM states: IDLE, BEAT0, BEAT1.
- in_ready = (state==IDLE) | (state==BEAT1 & out_ready). This is a combinational path from out_ready, intended to allow back-to-back vectors.
- Accept = in_valid & in_ready. On accept:
  - Register the full 2*INT*LENGTH widened result: the signExt output if in_mode=1, the zeroExt output if in_mode=0.
  - Next state = BEAT0.
- Latency: a vector accepted at edge N is presented with out_valid=1 from edge N onward, i.e. in cycle N+1.
- BEAT0:
  - out_data = result lanes 0..LENGTH/2-1; out_last=0.
  - If out_ready: next state = BEAT1. Otherwise hold.
- BEAT1:
  - out_data = result lanes LENGTH/2..LENGTH-1; out_last=1.
  - If out_ready: vec_cnt increments.
    - With a simultaneous accept: load the new result and go to BEAT0 (zero-bubble throughput of 1 vector per 2 cycles).
    - Without an accept: go to IDLE.
  - Otherwise hold.
- Stall: while out_valid & !out_ready, out_data and out_last stay bit-stable and in_ready=0. in_data is never observed in BEAT0.
- Out-of-protocol inputs:
  - out_ready in IDLE has no effect.
  - in_valid in BEAT0 is not accepted; the upstream must hold it.
- Width rules:
  - Widened lane k = {{INT{lane[INT-1]}}, lane} when sign mode, {INT'b0, lane} when zero mode.
  - Beat lane m occupies out_data[m*2*INT +: 2*INT].
- vec_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-vector: any pending beats are discarded. No partial vector is reported; vec_cnt clears.

Decomposition:
- Shared package/header (def.v alongside `INT8):
  - mode encodings EXT_ZERO=1'b0 and EXT_SIGN=1'b1;
  - FSM state encodings ST_IDLE=2'd0, ST_BEAT0=2'd1, ST_BEAT1=2'd2.
- One natural sub-module: ext_datapath, which instantiates signExt and zeroExt and the mode mux, and is purely combinational.
- The controller owns the FSM, result register, beat mux and counter.

Test Plan:
- Sign mode: lane0=8'h80, lane1=8'h7F, other lanes 0, out_ready=1.
  - Beat0 lane0=16'hFF80, lane1=16'h007F.
  - Beat1 all zero with out_last=1.
  - vec_cnt=1.
- Zero mode, all lanes 8'hFF: both beats all 16'h00FF; out_valid first seen in the cycle after accept.
- Back-to-back: in_valid held, out_ready=1, four vectors alternating modes.
  - Exactly 8 consecutive out_valid beats with no bubbles; out_last toggles every cycle.
  - vec_cnt=4.
- Backpressure: out_ready=0 for 5 cycles during BEAT0.
  - out_data and out_last stable; in_ready=0.
  - Release: beat1 follows on the next cycle.
- Reset: assert rst_n=0 while in BEAT1.
  - Asynchronously out_valid=0, busy=0, vec_cnt=0.
  - After release, the next vector is delivered correctly.
- Wrap: with CNT_W=4, deliver 17 vectors → vec_cnt=1.

Source files
------------

// File: rtl/ext_stream_ctrl_pkg.sv
// Shared encodings for the INT8 extension streaming controller.
package ext_stream_ctrl_pkg;

  localparam int INT8 = 8;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

endpackage

// File: rtl/ext_datapath.sv
// Combinational lane widening: per-lane signExt/zeroExt pair plus the mode mux.
module ext_datapath
  import ext_stream_ctrl_pkg::*;
#(
  parameter int INT    = INT8,
  parameter int LENGTH = 16
) (
  input  logic [INT*LENGTH-1:0]   in_data,
  input  logic                    in_mode,
  output logic [2*INT*LENGTH-1:0] wide
);

  logic [2*INT*LENGTH-1:0] sx;
  logic [2*INT*LENGTH-1:0] zx;

  for (genvar j = 0; j < LENGTH; j++) begin : g_lane
    signExt #(.INT(INT)) u_sign (
      .a (in_data[j*INT +: INT]),
      .y (sx[j*2*INT +: 2*INT])
    );
    zeroExt #(.INT(INT)) u_zero (
      .a (in_data[j*INT +: INT]),
      .y (zx[j*2*INT +: 2*INT])
    );
  end

  assign wide = (in_mode == EXT_SIGN) ? sx : zx;

endmodule

// File: rtl/signExt.sv
// Sign-extends one INT-bit lane to 2*INT bits.
module signExt #(
  parameter int INT = 8
) (
  input  logic [INT-1:0]   a,
  output logic [2*INT-1:0] y
);

  assign y = {{INT{a[INT-1]}}, a};

endmodule

// File: rtl/zeroExt.sv
// Zero-extends one INT-bit lane to 2*INT bits.
module zeroExt #(
  parameter int INT = 8
) (
  input  logic [INT-1:0]   a,
  output logic [2*INT-1:0] y
);

  assign y = {{INT{1'b0}}, a};

endmodule

// File: rtl/ext_stream_ctrl.sv
// Streaming sequencer: widens one packed vector per handshake and emits it
// as two input-width beats (lower lanes first) with valid/ready.
module ext_stream_ctrl
  import ext_stream_ctrl_pkg::*;
#(
  parameter int INT    = INT8,
  parameter int LENGTH = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT*LENGTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT*LENGTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      vec_cnt
);

  localparam int HALF_W = INT * LENGTH;
  localparam int FULL_W = 2 * HALF_W;

  state_t              state_r;
  state_t              state_nxt;
  logic [FULL_W-1:0]   wide_s;
  logic [FULL_W-1:0]   result_r;
  logic [FULL_W-1:0]   result_nxt;
  logic [HALF_W-1:0]   out_data_r;
  logic [HALF_W-1:0]   out_data_nxt;
  logic                out_valid_r;
  logic                out_last_r;
  logic [CNT_W-1:0]    vec_cnt_r;
  logic                load_s;
  logic                cnt_inc_s;

  ext_datapath #(.INT(INT), .LENGTH(LENGTH)) u_datapath (
    .in_data (in_data),
    .in_mode (in_mode),
    .wide    (wide_s)
  );

  // Combinational out_ready path lets a new vector load as the last beat leaves.
  assign in_ready = (state_r == ST_IDLE) | ((state_r == ST_BEAT1) & out_ready);

  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          load_s    = 1'b1;
          state_nxt = ST_BEAT0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (out_ready) begin
          state_nxt = ST_BEAT1;
        end else begin
          state_nxt = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        if (out_ready) begin
          cnt_inc_s = 1'b1;
          if (in_valid) begin
            load_s    = 1'b1;
            state_nxt = ST_BEAT0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          state_nxt = ST_BEAT1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so the beat is chosen from the next state/result.
  always_comb begin
    result_nxt   = result_r;
    out_data_nxt = out_data_r;
    if (load_s) begin
      result_nxt = wide_s;
    end else begin
      result_nxt = result_r;
    end
    case (state_nxt)
      ST_BEAT0: out_data_nxt = result_nxt[HALF_W-1:0];
      ST_BEAT1: out_data_nxt = result_nxt[FULL_W-1:HALF_W];
      default:  out_data_nxt = out_data_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      vec_cnt_r   <= '0;
    end else begin
      state_r     <= state_nxt;
      result_r    <= result_nxt;
      out_data_r  <= out_data_nxt;
      out_valid_r <= (state_nxt != ST_IDLE);
      out_last_r  <= (state_nxt == ST_BEAT1);
      if (cnt_inc_s) begin
        vec_cnt_r <= vec_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = (state_r != ST_IDLE);
  assign vec_cnt   = vec_cnt_r;

endmodule

// File: tb/tb_ext_stream_ctrl.sv
// Directed bench for ext_stream_ctrl (INT=8, LENGTH=16, CNT_W=4).
module tb_ext_stream_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic [3:0]   vec_cnt;

  int checks = 0;
  int errors = 0;

  ext_stream_ctrl #(.INT(8), .LENGTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .vec_cnt   (vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beat h (0 = lanes 0..7, 1 = lanes 8..15) of a widened vector.
  function automatic logic [127:0] ext_half(input logic [127:0] d, input logic m, input int h);
    logic [127:0] r;
    logic [7:0]   lane;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      lane = d[(h*8+k)*8 +: 8];
      r[k*16 +: 16] = m ? {{8{lane[7]}}, lane} : {8'h00, lane};
    end
    return r;
  endfunction

  function automatic logic [127:0] pattern(input int v);
    logic [127:0] d;
    for (int j = 0; j < 16; j++) d[j*8 +: 8] = 8'((j * 29 + v * 71 + 3) & 255);
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp0;
  logic [127:0] exp1;
  logic [127:0] vdat;
  int           cnt_model;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    cnt_model = 0;
    #12;
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_last",  {127'b0, out_last},  128'd0);
    check("rst_out_data",  out_data,            128'd0);
    check("rst_busy",      {127'b0, busy},      128'd0);
    check("rst_vec_cnt",   {124'b0, vec_cnt},   128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {127'b0, in_ready}, 128'd1);

    // Sign mode: lane0=80, lane1=7F
    in_data = '0; in_data[7:0] = 8'h80; in_data[15:8] = 8'h7F;
    in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sgn_b0_valid", {127'b0, out_valid}, 128'd1);
    check("sgn_b0_last",  {127'b0, out_last},  128'd0);
    check("sgn_b0_data",  out_data, 128'h0000_0000_0000_0000_0000_0000_007F_FF80);
    tick();
    check("sgn_b1_last",  {127'b0, out_last},  128'd1);
    check("sgn_b1_data",  out_data, 128'd0);
    tick();
    check("sgn_idle_valid", {127'b0, out_valid}, 128'd0);
    check("sgn_vec_cnt",    {124'b0, vec_cnt},   128'd1);

    // Zero mode, all lanes FF
    in_data = {16{8'hFF}}; in_mode = 1'b0; in_valid = 1'b1;
    check("zro_pre_valid", {127'b0, out_valid}, 128'd0);
    tick();
    in_valid = 1'b0;
    check("zro_b0_valid", {127'b0, out_valid}, 128'd1);
    check("zro_b0_data",  out_data, {8{16'h00FF}});
    tick();
    check("zro_b1_last",  {127'b0, out_last}, 128'd1);
    check("zro_b1_data",  out_data, {8{16'h00FF}});
    tick();
    check("zro_vec_cnt",  {124'b0, vec_cnt}, 128'd2);
    cnt_model = 2;

    // Back-to-back: four vectors alternating modes, in_valid held
    in_data = pattern(0); in_mode = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      tick();
      vdat = pattern(b / 2);
      check("b2b_valid", {127'b0, out_valid}, 128'd1);
      check("b2b_last",  {127'b0, out_last},  {127'b0, 1'(b % 2)});
      check("b2b_data",  out_data, ext_half(vdat, 1'((b / 2) % 2), b % 2));
      check("b2b_in_ready", {127'b0, in_ready}, {127'b0, 1'(b % 2)});
      if (b % 2 == 0) begin
        if (b == 6) begin
          in_valid = 1'b0;
        end else begin
          in_data = pattern(b / 2 + 1);
          in_mode = 1'((b / 2 + 1) % 2);
        end
      end
    end
    tick();
    check("b2b_end_valid", {127'b0, out_valid}, 128'd0);
    cnt_model = cnt_model + 4;
    check("b2b_vec_cnt", {124'b0, vec_cnt}, 128'(cnt_model % 16));

    // Backpressure in BEAT0
    vdat = pattern(9); in_data = vdat; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    exp0 = ext_half(vdat, 1'b1, 0);
    exp1 = ext_half(vdat, 1'b1, 1);
    tick();
    in_data = pattern(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    {127'b0, out_valid}, 128'd1);
      check("bp_last",     {127'b0, out_last},  128'd0);
      check("bp_data",     out_data, exp0);
      check("bp_in_ready", {127'b0, in_ready},  128'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_rel_last", {127'b0, out_last}, 128'd1);
    check("bp_rel_data", out_data, exp1);
    tick();
    cnt_model = cnt_model + 1;
    check("bp_vec_cnt", {124'b0, vec_cnt}, 128'(cnt_model % 16));

    // Reset asserted while in BEAT1
    in_data = pattern(11); in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("mid_in_beat1", {127'b0, out_last}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {127'b0, out_valid}, 128'd0);
    check("mid_rst_busy",  {127'b0, busy},      128'd0);
    check("mid_rst_cnt",   {124'b0, vec_cnt},   128'd0);
    tick();
    rst_n = 1'b1;
    vdat = pattern(12); in_data = vdat; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_b0_data", out_data, ext_half(vdat, 1'b1, 0));
    tick();
    check("post_b1_data", out_data, ext_half(vdat, 1'b1, 1));
    tick();
    check("post_vec_cnt", {124'b0, vec_cnt}, 128'd1);

    // Counter wrap: 17 vectors from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_data = pattern(13); in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      tick();
      if (c == 32) in_valid = 1'b0;
    end
    tick();
    check("wrap_vec_cnt", {124'b0, vec_cnt}, 128'd1);
    check("wrap_idle",    {127'b0, busy},    128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
